// File: rtl/capture_sequencer.sv
// capture_sequencer: shutter-driven erase/expose/two-row-readout sequencer with frame-store handoff
module capture_sequencer #(
  parameter int EXP_MIN = 2,
  parameter int EXP_MAX = 30,
  parameter int READ_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic       Abort,
  input  logic [4:0] Exp_time,
  input  logic       Frame_ready,
  output logic       Erase,
  output logic       Expose,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC,
  output logic       Frame_valid,
  output logic       Busy,
  output logic [7:0] Frame_count
);
  localparam int CW = $clog2((EXP_MAX > READ_CYCLES ? EXP_MAX : READ_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, EXPOSE, GAP_EXP, READ1, GAP_ROW, READ2, HANDOFF} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] exp_c;
  logic pending, pending_n, start, done, cnt_zero;
  assign exp_c = Exp_time < 5'(EXP_MIN) ? 5'(EXP_MIN) : Exp_time > 5'(EXP_MAX) ? 5'(EXP_MAX) : Exp_time;
  assign start = state == IDLE && (Init || pending) && !Abort;
  assign done = state == HANDOFF && Frame_ready && !Abort;
  assign cnt_zero = cnt == '0;
  assign pending_n = (start || Abort) ? 1'b0 : (Init && state != IDLE) ? 1'b1 : pending;
  always_comb begin
    state_n = state;
    cnt_n = cnt - CW'(1);
    case (state)
      IDLE: begin
        state_n = start ? EXPOSE : IDLE;
        cnt_n = start ? CW'(exp_c - 5'd1) : cnt;
      end
      EXPOSE: state_n = cnt_zero ? GAP_EXP : EXPOSE;
      GAP_EXP: begin
        state_n = READ1;
        cnt_n = CW'(READ_CYCLES - 1);
      end
      READ1: state_n = cnt_zero ? GAP_ROW : READ1;
      GAP_ROW: begin
        state_n = READ2;
        cnt_n = CW'(READ_CYCLES - 1);
      end
      READ2: state_n = cnt_zero ? HANDOFF : READ2;
      HANDOFF: begin
        state_n = Frame_ready ? IDLE : HANDOFF;
        cnt_n = cnt;
      end
      default: state_n = IDLE;
    endcase
    if (Abort && state != IDLE) state_n = IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      pending <= 1'b0;
      Frame_count <= 8'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pending <= pending_n;
      Frame_count <= done ? Frame_count + 8'd1 : Frame_count;
    end
  end
  assign Erase = state == IDLE;
  assign Expose = state == EXPOSE;
  assign NRE_1 = state != READ1;
  assign NRE_2 = state != READ2;
  assign ADC = (state == READ1 || state == READ2) && cnt_zero;
  assign Frame_valid = state == HANDOFF;
  assign Busy = state != IDLE;
endmodule
